// File: rtl/dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dmem_responder                                             |
// | Description : Single-outstanding data-memory responder with programmable |
// |               response latency and valid/ready request/response channels.|
// |               Optional macro DMEM_RAND_DELAY_EN adds a per-request random |
// |               extra delay of 0..3 cycles from an 8-bit LFSR.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dmem_responder #(
   parameter logic [31:0] BASE    = 32'h8000_0000,
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wmask,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam logic [31:0] SPAN = 32'(4 * DEPTH);
   // Wide enough for LATENCY plus the optional random extra delay.
   localparam int unsigned CW   = 9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wen_q, wen_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    wmask_q, wmask_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [31:0]   rsp_rdata_q, rsp_rdata_d;
   logic          rsp_err_q, rsp_err_d;

   logic [31:0]   mem_q [DEPTH];

   logic          accept;
   logic [CW-1:0] delay;
   logic          do_access;
   logic          mem_we;
   logic          acc_wen;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic [3:0]    acc_wmask;
   logic [31:0]   acc_off;
   logic          acc_in_range;
   logic [AW-1:0] acc_idx;

   assign req_ready = (state_q == ST_IDLE) && !rst;
   assign accept    = req_valid && req_ready;

`ifdef DMEM_RAND_DELAY_EN
   logic [7:0] lfsr_q, lfsr_d;

   // Fibonacci LFSR (taps 8,6,5,4) stepping once per accepted request.
   always_comb begin
      lfsr_d = lfsr_q;
      if (accept) begin
         lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
   end

   // LFSR register; seed restored on reset.
   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= 8'hA5;
      else     lfsr_q <= lfsr_d;
   end

   // Extra delay uses the LFSR value before this request advances it.
   assign delay = CW'(LATENCY) + CW'(lfsr_q[1:0]);
`else
   assign delay = CW'(LATENCY);
`endif

   // With zero delay the access runs on the accept edge, so operands come
   // straight from the request port; otherwise from the latched copy.
   assign acc_wen      = (state_q == ST_IDLE) ? req_wen   : wen_q;
   assign acc_addr     = (state_q == ST_IDLE) ? req_addr  : addr_q;
   assign acc_wdata    = (state_q == ST_IDLE) ? req_wdata : wdata_q;
   assign acc_wmask    = (state_q == ST_IDLE) ? req_wmask : wmask_q;
   assign acc_off      = acc_addr - BASE;
   assign acc_in_range = acc_off < SPAN;
   assign acc_idx      = acc_off[AW+1:2];

   // The access happens exactly once: on the edge that enters RESP.
   assign do_access = !rst && ((accept && (delay == '0)) ||
                               ((state_q == ST_BUSY) && (cnt_q == CW'(1))));
   assign mem_we    = do_access && acc_wen && acc_in_range;

   // Next-state, counter, request latch and response computation.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wen_d       = wen_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wmask_d     = wmask_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               wen_d   = req_wen;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               wmask_d = req_wmask;
               cnt_d   = delay;
               state_d = (delay == '0) ? ST_RESP : ST_BUSY;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      rsp_valid_d = (state_d == ST_RESP);
      if (do_access) begin
         rsp_err_d   = !acc_in_range;
         rsp_rdata_d = (acc_in_range && !acc_wen) ? mem_q[acc_idx] : 32'h0;
      end
   end

   // Control and response registers; reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         wen_q       <= 1'b0;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         wmask_q     <= 4'h0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wen_q       <= wen_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wmask_q     <= wmask_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Byte-lane masked write into the (unreset) storage array.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_wmask[b]) mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dmem_responder                                          |
// | Description : Self-checking bench for dmem_responder. Instance A uses    |
// |               LATENCY=2/DEPTH=1024, instance B uses LATENCY=0/DEPTH=16.  |
// |               Honours DMEM_RAND_DELAY_EN in its delay model.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_dmem_responder;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Inputs indexed by instance: [0] = A, [1] = B.
   logic [1:0]       req_valid, req_wen, rsp_ready;
   logic [1:0][31:0] req_addr, req_wdata;
   logic [1:0][3:0]  req_wmask;

   logic        req_ready_a, rsp_valid_a, rsp_err_a;
   logic        req_ready_b, rsp_valid_b, rsp_err_b;
   logic [31:0] rsp_rdata_a, rsp_rdata_b;

   logic [1:0]  req_ready_v, rsp_valid_v, rsp_err_v;
   logic [31:0] rsp_rdata_v [2];
   assign req_ready_v    = {req_ready_b, req_ready_a};
   assign rsp_valid_v    = {rsp_valid_b, rsp_valid_a};
   assign rsp_err_v      = {rsp_err_b, rsp_err_a};
   assign rsp_rdata_v[0] = rsp_rdata_a;
   assign rsp_rdata_v[1] = rsp_rdata_b;

   dmem_responder #(.BASE(BASE), .DEPTH(1024), .LATENCY(2)) u_dut_a (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready_a), .req_wen(req_wen[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
      .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
   );

   dmem_responder #(.BASE(BASE), .DEPTH(16), .LATENCY(0)) u_dut_b (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready_b), .req_wen(req_wen[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Delay model: programmed latency plus, when enabled, the low two bits of
   // an LFSR that steps once per accepted request.
   int         lat_cfg [2] = '{2, 0};
   logic [7:0] mlfsr   [2];

   task automatic model_delay(input int k, output int d);
      d = lat_cfg[k];
`ifdef DMEM_RAND_DELAY_EN
      d = d + int'(mlfsr[k][1:0]);
      mlfsr[k] = {mlfsr[k][6:0], mlfsr[k][7] ^ mlfsr[k][5] ^ mlfsr[k][4] ^ mlfsr[k][3]};
`endif
   endtask

   // Counting the cycle in which the request is accepted as cycle 0,
   // rsp_valid must first be seen in cycle 1+D.
   task automatic xact(input int k, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask, input int hold,
                       input logic chk_data, input logic [31:0] exp_rd, input logic exp_err,
                       input string tag);
      int d;
      int cyc;
      logic [31:0] rd0;
      logic        er0;
      cyc = 0;
      while (req_ready_v[k] !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, " req_ready"}, 64'(req_ready_v[k]), 64'd1);
      req_valid[k] = 1'b1;
      req_wen[k]   = wen;
      req_addr[k]  = addr;
      req_wdata[k] = wdata;
      req_wmask[k] = mask;
      model_delay(k, d);
      @(posedge clk);
      #1 req_valid[k] = 1'b0;
      req_wdata[k] = $urandom;
      @(negedge clk);
      cyc = 1;
      while (rsp_valid_v[k] !== 1'b1 && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, " latency"}, 64'(cyc), 64'(1 + d));
      rd0 = rsp_rdata_v[k];
      er0 = rsp_err_v[k];
      if (chk_data) check({tag, " rdata"}, 64'(rd0), 64'(exp_rd));
      check({tag, " err"}, 64'(er0), 64'(exp_err));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({tag, " hold"}, {rsp_valid_v[k], rsp_rdata_v[k], rsp_err_v[k], req_ready_v[k]},
               {1'b1, rd0, er0, 1'b0});
      end
      rsp_ready[k] = 1'b1;
      @(posedge clk);
      #1 rsp_ready[k] = 1'b0;
      @(negedge clk);
      check({tag, " idle"}, 64'({rsp_valid_v[k], req_ready_v[k]}), 64'(2'b01));
   endtask

   typedef struct {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
      int          hold;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t tbl [15];
   logic [31:0] mm [int];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          d;
      logic        any_valid;
      logic [31:0] a, off, nv;
      logic        w, inr, chk;
      logic [3:0]  m;
      int          widx;

      tbl[0]  = '{1'b1, 32'h8000_0000, 32'h1111_1111, 4'hF, 0, 32'h0, 1'b0};
      tbl[1]  = '{1'b1, 32'h8000_0FFC, 32'h2222_2222, 4'hF, 0, 32'h0, 1'b0};
      tbl[2]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0};
      tbl[3]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0};
      tbl[4]  = '{1'b1, 32'h8000_0010, 32'h00AB_0000, 4'h4, 0, 32'h0, 1'b0};
      tbl[5]  = '{1'b0, 32'h8000_0013, 32'h0,         4'hF, 5, 32'hDEAB_BEEF, 1'b0};
      tbl[6]  = '{1'b1, 32'h7FFF_FFFC, 32'h1234_5678, 4'hF, 0, 32'h0, 1'b1};
      tbl[7]  = '{1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF, 2, 32'h0, 1'b1};
      tbl[8]  = '{1'b0, 32'h8000_1000, 32'h0,         4'h0, 0, 32'h0, 1'b1};
      tbl[9]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 0, 32'h1111_1111, 1'b0};
      tbl[10] = '{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 0, 32'h2222_2222, 1'b0};
      tbl[11] = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0, 32'h0, 1'b0};
      tbl[12] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 1, 32'hDEAB_BEEF, 1'b0};
      tbl[13] = '{1'b1, 32'h8000_0020, 32'h3333_3333, 4'hF, 0, 32'h0, 1'b0};
      tbl[14] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 0, 32'h0, 1'b1};

      rst = 1'b1;
      req_valid = '0; req_wen = '0; rsp_ready = '0;
      req_addr = '0; req_wdata = '0; req_wmask = '0;
      mlfsr[0] = 8'hA5;
      mlfsr[1] = 8'hA5;
      repeat (3) @(negedge clk);
      check("reset rsp_valid", 64'(rsp_valid_v), 64'd0);
      check("reset rsp_err", 64'(rsp_err_v), 64'd0);
      check("reset rdata a", 64'(rsp_rdata_v[0]), 64'd0);
      check("reset rdata b", 64'(rsp_rdata_v[1]), 64'd0);
      check("reset req_ready", 64'(req_ready_v), 64'd0);
      rst = 1'b0;
      #1 check("post-reset req_ready", 64'(req_ready_v), 64'(2'b11));

      // Directed table on instance A.
      for (int i = 0; i < 15; i++) begin
         xact(0, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].mask, tbl[i].hold,
              1'b1, tbl[i].exp_rd, tbl[i].exp_err, $sformatf("vec%0d", i));
      end

      // Reset while BUSY drops the pending write and its response.
      @(negedge clk);
      req_valid[0] = 1'b1; req_wen[0] = 1'b1; req_addr[0] = 32'h8000_0020;
      req_wdata[0] = 32'hCAFE_F00D; req_wmask[0] = 4'hF;
      model_delay(0, d);
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      @(negedge clk);
      check("busy state", 64'({rsp_valid_v[0], req_ready_v[0]}), 64'(2'b00));
      rst = 1'b1;
      mlfsr[0] = 8'hA5;
      mlfsr[1] = 8'hA5;
      @(negedge clk);
      rst = 1'b0;
      #1 check("reset in busy idle", 64'({rsp_valid_v[0], req_ready_v[0]}), 64'(2'b01));
      any_valid = 1'b0;
      repeat (5) begin
         @(negedge clk);
         any_valid = any_valid | rsp_valid_v[0];
      end
      check("no rsp after reset", 64'(any_valid), 64'd0);
      xact(0, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, 1'b1, 32'h3333_3333, 1'b0, "dropped write");

      // Zero-latency instance B.
      xact(1, 1'b1, 32'h8000_0008, 32'hA5A5_0F0F, 4'hF, 0, 1'b1, 32'h0, 1'b0, "b write");
      xact(1, 1'b0, 32'h8000_0008, 32'h0, 4'h0, 2, 1'b1, 32'hA5A5_0F0F, 1'b0, "b read");
      xact(1, 1'b1, 32'h8000_0040, 32'h5555_5555, 4'hF, 0, 1'b1, 32'h0, 1'b1, "b oor");
      xact(1, 1'b0, 32'h8000_003C, 32'h0, 4'h0, 0, 1'b0, 32'h0, 1'b0, "b top word");

      // Randomized traffic on A against an address-level memory model.
      mm[0]    = 32'h1111_1111;
      mm[1023] = 32'h2222_2222;
      mm[4]    = 32'hDEAB_BEEF;
      mm[8]    = 32'h3333_3333;
      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            6:       a = BASE + 32'd4092;
            7:       a = BASE - 32'(4 * $urandom_range(1, 4));
            8:       a = BASE + 32'd4096 + 32'(4 * $urandom_range(0, 3));
            default: a = $urandom;
         endcase
         w   = 1'($urandom_range(0, 1));
         nv  = $urandom;
         m   = 4'($urandom_range(0, 15));
         off = a - BASE;
         inr = off < 32'd4096;
         widx = int'(off >> 2);
         chk = 1'b1;
         if (!inr) begin
            xact(0, w, a, nv, m, $urandom_range(0, 3), 1'b1, 32'h0, 1'b1, $sformatf("rnd%0d", it));
         end else if (w) begin
            if (mm.exists(widx)) begin
               for (int b = 0; b < 4; b++) if (m[b]) mm[widx][8*b +: 8] = nv[8*b +: 8];
            end else if (m == 4'hF) begin
               mm[widx] = nv;
            end
            xact(0, 1'b1, a, nv, m, $urandom_range(0, 3), 1'b1, 32'h0, 1'b0, $sformatf("rnd%0d", it));
         end else begin
            chk = mm.exists(widx);
            xact(0, 1'b0, a, nv, m, $urandom_range(0, 3), chk, chk ? mm[widx] : 32'h0, 1'b0,
                 $sformatf("rnd%0d", it));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
